alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Initiator side of the 32-bit ALU interface. Accepts operation requests on a
//  valid/ready port and encodes each one to the ALU's 4-bit control code. It
//  drives the registered operands, waits a settle window, captures the result
//  and C/V/N/Z flags, and returns them on a valid/ready response port.
//  Sits between issue logic and the combinational ALU; the ALU is external.
// PARAMETERS
//  SETTLE_CYCLES  1  cycles operands are held on the ALU before capture (1..15)
//  TAG_W          4  width of the request tag echoed in the response
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  reset_n    in   1      asynchronous active-low reset
//  req_valid  in   1      request present
//  req_ready  out  1      sequencer can accept a request (high only in IDLE)
//  req_op     in   4      operation, op_e from the package
//  req_a      in   32     operand A
//  req_b      in   32     operand B
//  req_tag    in   TAG_W  opaque tag
//  alu_a      out  32     operand A to the ALU (registered)
//  alu_b      out  32     operand B to the ALU (registered)
//  alu_cntl   out  4      ALU control code (registered)
//  alu_out    in   32     ALU result
//  alu_c, alu_v, alu_n, alu_z  in 1 each  ALU flags (C/V may be X on logic ops)
//  rsp_valid  out  1      response present
//  rsp_ready  in   1      consumer accepts response
//  rsp_result out  32     captured result
//  rsp_flags  out  4      {C,V,N,Z}, never X
//  rsp_err    out  1      illegal op; result/flags are 0
//  rsp_tag    out  TAG_W  echo of req_tag
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; rsp_valid=0; alu_a/alu_b=0;
//   alu_cntl=4'b0000; rsp_result/flags/err/tag=0; settle counter=0.
//  FSM IDLE -> DRIVE -> CAPTURE -> RESP -> IDLE.
//   IDLE:    req_valid&&req_ready: register operands, tag and encoded cntl.
//            Legal op -> DRIVE with counter=SETTLE_CYCLES-1.
//            Illegal op -> RESP with rsp_err=1, result=0, flags=0, alu_* unchanged.
//   DRIVE:   hold alu_*; counter==0 -> CAPTURE, else decrement.
//   CAPTURE: latch alu_out and flags into rsp_*; -> RESP.
//   RESP:    rsp_valid=1 with fields stable until rsp_ready; on handshake -> IDLE.
//  Latency (legal op, rsp_ready=1): req handshake edge to rsp_valid =
//   SETTLE_CYCLES+2 cycles. Throughput: one op per SETTLE_CYCLES+3 cycles.
//  Encoding: AND 0000, OR 0001, ADDU 0010, XOR 0011, SLTU 0101, SUBU 0110,
//   NAND 0111, ADD 1010, NOR 1100, SHL1 1101, SUB 1110, SLT 1111.
//   Any other op_e value is illegal.
//  Flag masking: for AND/OR/XOR/NAND/NOR/SLT/SLTU, C=V=0. Other ops pass ALU
//   C and V. N and Z always pass through.
//  A request offered outside IDLE is ignored; req_ready=0 there.
//  rsp_ready held low stalls in RESP indefinitely with no loss of response.
//  Reset mid-operation aborts any op: outputs return to reset values next
//   evaluation, and the in-flight response is discarded.
// STRUCTURE
//  Package alu_seq_pkg: op_e enum, ALU cntl localparams, state_e enum, and
//   function is_logic_op().
//  One sub-module: alu_op_encoder (combinational op_e -> {cntl, legal, logic}).
// TESTING
//  ADD a=7FFFFFFF b=1 -> cntl 1010; result 80000000; flags C0 V1 N1 Z0; tag echoed.
//  SUBU a=0 b=1 -> result FFFFFFFF; C=1 V=1 N=0 Z=0.
//  AND a=F0F0F0F0 b=0F0F0F0F -> result 0; flags 0001; C and V never X.
//  Illegal op -> no cntl change; after 1 cycle, rsp_valid with err=1, result 0.
//  rsp_ready low 5 cycles -> response stable; req_ready=0; a second req is not taken.
//  reset_n low during DRIVE -> rsp_valid=0, req_ready=1, alu_cntl=0 immediately.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// Shared types for the ALU op sequencer: operation codes, ALU control codes,
// FSM states and the captured flag bundle.
package alu_seq_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned CNTL_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 4'd0,
        OP_OR   = 4'd1,
        OP_ADDU = 4'd2,
        OP_XOR  = 4'd3,
        OP_SLTU = 4'd4,
        OP_SUBU = 4'd5,
        OP_NAND = 4'd6,
        OP_ADD  = 4'd7,
        OP_NOR  = 4'd8,
        OP_SHL1 = 4'd9,
        OP_SUB  = 4'd10,
        OP_SLT  = 4'd11
    } op_e;

    localparam logic [CNTL_W-1:0] CNTL_AND  = 4'b0000;
    localparam logic [CNTL_W-1:0] CNTL_OR   = 4'b0001;
    localparam logic [CNTL_W-1:0] CNTL_ADDU = 4'b0010;
    localparam logic [CNTL_W-1:0] CNTL_XOR  = 4'b0011;
    localparam logic [CNTL_W-1:0] CNTL_SLTU = 4'b0101;
    localparam logic [CNTL_W-1:0] CNTL_SUBU = 4'b0110;
    localparam logic [CNTL_W-1:0] CNTL_NAND = 4'b0111;
    localparam logic [CNTL_W-1:0] CNTL_ADD  = 4'b1010;
    localparam logic [CNTL_W-1:0] CNTL_NOR  = 4'b1100;
    localparam logic [CNTL_W-1:0] CNTL_SHL1 = 4'b1101;
    localparam logic [CNTL_W-1:0] CNTL_SUB  = 4'b1110;
    localparam logic [CNTL_W-1:0] CNTL_SLT  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    typedef struct packed {
        logic c;
        logic v;
        logic n;
        logic z;
    } alu_flags_t;

    // Ops whose carry/overflow outputs are meaningless and must be masked.
    function automatic logic is_logic_op(op_e op);
        case (op)
            OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_SLT, OP_SLTU: return 1'b1;
            default:                                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request, response and ALU-side signals of the op sequencer.
// slave = sequencer side, master = issue logic / ALU / consumer side.
interface alu_op_sequencer_if
    import alu_seq_pkg::*;
#(
    parameter int unsigned TAG_W = 4
);
    logic              req_valid;
    logic              req_ready;
    op_e               req_op;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [TAG_W-1:0]  req_tag;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [CNTL_W-1:0] alu_cntl;
    logic [DATA_W-1:0] alu_out;
    logic              alu_c;
    logic              alu_v;
    logic              alu_n;
    logic              alu_z;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic [3:0]        rsp_flags;
    logic              rsp_err;
    logic [TAG_W-1:0]  rsp_tag;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag,
        input  alu_out, alu_c, alu_v, alu_n, alu_z,
        input  rsp_ready,
        output req_ready,
        output alu_a, alu_b, alu_cntl,
        output rsp_valid, rsp_result, rsp_flags, rsp_err, rsp_tag
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag,
        output alu_out, alu_c, alu_v, alu_n, alu_z,
        output rsp_ready,
        input  req_ready,
        input  alu_a, alu_b, alu_cntl,
        input  rsp_valid, rsp_result, rsp_flags, rsp_err, rsp_tag
    );

endinterface

// File: rtl/alu_op_sequencer_encoder.sv
// Combinational translation of an op_e request into the ALU control code,
// plus legality and logic-op classification.
module alu_op_encoder
    import alu_seq_pkg::*;
(
    input  op_e               op_i,
    output logic [CNTL_W-1:0] cntl_c,
    output logic              legal_c,
    output logic              is_logic_c
);

    always_comb begin
        cntl_c  = CNTL_AND;
        legal_c = 1'b1;
        case (op_i)
            OP_AND:  cntl_c = CNTL_AND;
            OP_OR:   cntl_c = CNTL_OR;
            OP_ADDU: cntl_c = CNTL_ADDU;
            OP_XOR:  cntl_c = CNTL_XOR;
            OP_SLTU: cntl_c = CNTL_SLTU;
            OP_SUBU: cntl_c = CNTL_SUBU;
            OP_NAND: cntl_c = CNTL_NAND;
            OP_ADD:  cntl_c = CNTL_ADD;
            OP_NOR:  cntl_c = CNTL_NOR;
            OP_SHL1: cntl_c = CNTL_SHL1;
            OP_SUB:  cntl_c = CNTL_SUB;
            OP_SLT:  cntl_c = CNTL_SLT;
            default: legal_c = 1'b0;
        endcase
        is_logic_c = legal_c && is_logic_op(op_i);
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator for an external combinational ALU: takes one request, drives
// registered operands for a settle window, captures result/flags, responds.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned TAG_W         = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    alu_op_sequencer_if.slave bus
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [CNTL_W-1:0] alu_cntl_q, alu_cntl_d;
    logic              logic_op_q, logic_op_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    alu_flags_t        rsp_flags_q, rsp_flags_d;
    logic              rsp_err_q, rsp_err_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;

    logic [CNTL_W-1:0] enc_cntl_c;
    logic              enc_legal_c;
    logic              enc_logic_c;

    alu_op_encoder u_encoder (
        .op_i       (bus.req_op),
        .cntl_c     (enc_cntl_c),
        .legal_c    (enc_legal_c),
        .is_logic_c (enc_logic_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_cntl_q   <= CNTL_AND;
            logic_op_q   <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
            rsp_tag_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_cntl_q   <= alu_cntl_d;
            logic_op_q   <= logic_op_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_err_q    <= rsp_err_d;
            rsp_tag_q    <= rsp_tag_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_cntl_d   = alu_cntl_q;
        logic_op_d   = logic_op_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_err_d    = rsp_err_q;
        rsp_tag_d    = rsp_tag_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    rsp_tag_d = bus.req_tag;
                    if (enc_legal_c) begin
                        alu_a_d    = bus.req_a;
                        alu_b_d    = bus.req_b;
                        alu_cntl_d = enc_cntl_c;
                        logic_op_d = enc_logic_c;
                        rsp_err_d  = 1'b0;
                        cnt_d      = CNT_LOAD;
                        state_d    = ST_DRIVE;
                    end else begin
                        // Illegal ops never reach the ALU; answer immediately.
                        rsp_err_d    = 1'b1;
                        rsp_result_d = '0;
                        rsp_flags_d  = '0;
                        state_d      = ST_RESP;
                    end
                end
            end
            ST_DRIVE: begin
                if (cnt_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                rsp_result_d  = bus.alu_out;
                rsp_flags_d.c = logic_op_q ? 1'b0 : bus.alu_c;
                rsp_flags_d.v = logic_op_q ? 1'b0 : bus.alu_v;
                rsp_flags_d.n = bus.alu_n;
                rsp_flags_d.z = bus.alu_z;
                state_d       = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_cntl   = alu_cntl_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_tag    = rsp_tag_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: external ALU model, directed vector table,
// stall/reset sequences and randomized ops against an arithmetic reference.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    localparam int unsigned TAG_W   = 4;
    localparam int unsigned SETTLE  = 3;
    localparam int          LAT     = SETTLE + 2;
    localparam int          TIMEOUT = 64;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        n;
        logic        z;
    } alu_res_t;

    typedef struct {
        op_e         op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [3:0]  cntl;
        logic [31:0] res;
        logic [3:0]  flags;
        logic        err;
    } vec_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    alu_op_sequencer_if #(.TAG_W(TAG_W)) bus ();

    alu_op_sequencer #(.SETTLE_CYCLES(SETTLE), .TAG_W(TAG_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] spec_cntl(op_e op);
        case (op)
            OP_AND:  return 4'b0000;
            OP_OR:   return 4'b0001;
            OP_ADDU: return 4'b0010;
            OP_XOR:  return 4'b0011;
            OP_SLTU: return 4'b0101;
            OP_SUBU: return 4'b0110;
            OP_NAND: return 4'b0111;
            OP_ADD:  return 4'b1010;
            OP_NOR:  return 4'b1100;
            OP_SHL1: return 4'b1101;
            OP_SUB:  return 4'b1110;
            OP_SLT:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic bit spec_legal(op_e op);
        case (op)
            OP_AND, OP_OR, OP_ADDU, OP_XOR, OP_SLTU, OP_SUBU,
            OP_NAND, OP_ADD, OP_NOR, OP_SHL1, OP_SUB, OP_SLT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit spec_logic(op_e op);
        return op inside {OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_SLT, OP_SLTU};
    endfunction

    function automatic alu_res_t ref_alu(op_e op, logic [31:0] a, logic [31:0] b);
        alu_res_t   o;
        logic [32:0] s;
        o = '0;
        s = '0;
        case (op)
            OP_AND:  o.r = a & b;
            OP_OR:   o.r = a | b;
            OP_XOR:  o.r = a ^ b;
            OP_NAND: o.r = ~(a & b);
            OP_NOR:  o.r = ~(a | b);
            OP_ADD, OP_ADDU: begin
                s   = {1'b0, a} + {1'b0, b};
                o.r = s[31:0];
                o.c = s[32];
                o.v = (op == OP_ADD) ? ((a[31] == b[31]) && (o.r[31] != a[31])) : s[32];
            end
            OP_SUB, OP_SUBU: begin
                s   = {1'b0, a} - {1'b0, b};
                o.r = s[31:0];
                o.c = s[32];
                o.v = (op == OP_SUB) ? ((a[31] != b[31]) && (o.r[31] != a[31])) : s[32];
            end
            OP_SLT:  o.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: o.r = (a < b) ? 32'd1 : 32'd0;
            OP_SHL1: begin
                o.r = {a[30:0], 1'b0};
                o.c = a[31];
                o.v = a[31] ^ a[30];
            end
            default: ;
        endcase
        o.n = (op == OP_ADDU || op == OP_SUBU) ? 1'b0 : o.r[31];
        o.z = (o.r == 32'd0);
        return o;
    endfunction

    // External ALU: decodes the control code; logic ops drive garbage on C/V.
    always_comb begin
        op_e      sel;
        alu_res_t r;
        sel = OP_AND;
        for (int i = 0; i < 16; i++)
            if (spec_legal(op_e'(4'(i))) && spec_cntl(op_e'(4'(i))) == bus.alu_cntl)
                sel = op_e'(4'(i));
        r = ref_alu(sel, bus.alu_a, bus.alu_b);
        bus.alu_out = r.r;
        bus.alu_n   = r.n;
        bus.alu_z   = r.z;
        bus.alu_c   = spec_logic(sel) ? 1'b1 : r.c;
        bus.alu_v   = spec_logic(sel) ? 1'b1 : r.v;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound of %0d cycles expired", name, TIMEOUT);
    endtask

    // Issue one request at a negedge; return at the negedge where rsp_valid is seen.
    task automatic run_op(input op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag, output logic [3:0] cntl, output int lat);
        int guard = 0;
        while (!bus.req_ready && guard < TIMEOUT) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) fail_now("req_ready_wait");
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;
        cntl = bus.alu_cntl;
        lat  = 1;
        while (!bus.rsp_valid && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_rsp(input string tag_s, input op_e op, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] tag,
                             input logic [3:0] exp_cntl, input logic [3:0] cntl, input int lat);
        alu_res_t r;
        logic [3:0] f;
        bit legal;
        legal = spec_legal(op);
        r = ref_alu(op, a, b);
        f = spec_logic(op) ? {2'b00, r.n, r.z} : {r.c, r.v, r.n, r.z};
        chk({tag_s, "_latency"}, 32'(lat), legal ? 32'(LAT) : 32'd1);
        chk({tag_s, "_cntl"}, 32'(cntl), 32'(exp_cntl));
        chk({tag_s, "_result"}, bus.rsp_result, legal ? r.r : 32'd0);
        chk({tag_s, "_flags"}, 32'(bus.rsp_flags), legal ? 32'(f) : 32'd0);
        chk({tag_s, "_err"}, 32'(bus.rsp_err), legal ? 32'd0 : 32'd1);
        chk({tag_s, "_tag"}, 32'(bus.rsp_tag), 32'(tag));
        chk({tag_s, "_req_ready_busy"}, 32'(bus.req_ready), 32'd0);
    endtask

    task automatic finish_rsp(input string tag_s);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk({tag_s, "_rsp_valid_drop"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag_s, "_req_ready_back"}, 32'(bus.req_ready), 32'd1);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vec_t        vecs[$];
        logic [3:0]  cntl;
        logic [3:0]  prev_cntl;
        int          lat;
        int          seen;

        //            op            a             b             tag   cntl     result        flags    err
        vecs.push_back('{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 4'h5, 4'b1010, 32'h80000000, 4'b0110, 1'b0});
        vecs.push_back('{OP_SUBU, 32'h00000000, 32'h00000001, 4'hA, 4'b0110, 32'hFFFFFFFF, 4'b1100, 1'b0});
        vecs.push_back('{OP_AND,  32'hF0F0F0F0, 32'h0F0F0F0F, 4'h1, 4'b0000, 32'h00000000, 4'b0001, 1'b0});
        vecs.push_back('{OP_OR,   32'h12340000, 32'h00005678, 4'h2, 4'b0001, 32'h12345678, 4'b0000, 1'b0});
        vecs.push_back('{OP_XOR,  32'hFFFFFFFF, 32'h0000FFFF, 4'h3, 4'b0011, 32'hFFFF0000, 4'b0010, 1'b0});
        vecs.push_back('{OP_NAND, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h4, 4'b0111, 32'h00000000, 4'b0001, 1'b0});
        vecs.push_back('{OP_NOR,  32'h00000000, 32'h00000000, 4'h6, 4'b1100, 32'hFFFFFFFF, 4'b0010, 1'b0});
        vecs.push_back('{OP_ADDU, 32'hFFFFFFFF, 32'h00000001, 4'h7, 4'b0010, 32'h00000000, 4'b1101, 1'b0});
        vecs.push_back('{OP_SUB,  32'h80000000, 32'h00000001, 4'h8, 4'b1110, 32'h7FFFFFFF, 4'b0100, 1'b0});
        vecs.push_back('{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 4'h9, 4'b1111, 32'h00000001, 4'b0000, 1'b0});
        vecs.push_back('{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 4'hB, 4'b0101, 32'h00000000, 4'b0001, 1'b0});
        vecs.push_back('{OP_SHL1, 32'hC0000001, 32'h00000000, 4'hC, 4'b1101, 32'h80000002, 4'b1010, 1'b0});
        vecs.push_back('{op_e'(4'hC), 32'h11111111, 32'h22222222, 4'hD, 4'b1101, 32'h0, 4'b0000, 1'b1});
        vecs.push_back('{op_e'(4'hF), 32'h33333333, 32'h44444444, 4'hE, 4'b1101, 32'h0, 4'b0000, 1'b1});

        bus.req_valid = 1'b0;
        bus.req_op    = OP_AND;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_alu_a", bus.alu_a, 32'd0);
        chk("reset_alu_b", bus.alu_b, 32'd0);
        chk("reset_alu_cntl", 32'(bus.alu_cntl), 32'd0);
        chk("reset_rsp_fields", {bus.rsp_result[27:0], bus.rsp_flags}, 32'd0);
        chk("reset_rsp_err_tag", {27'd0, bus.rsp_err, bus.rsp_tag}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, cntl, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), vecs[i].err ? 32'd1 : 32'(LAT));
            chk($sformatf("vec%0d_cntl", i), 32'(cntl), 32'(vecs[i].cntl));
            chk($sformatf("vec%0d_result", i), bus.rsp_result, vecs[i].res);
            chk($sformatf("vec%0d_flags", i), 32'(bus.rsp_flags), 32'(vecs[i].flags));
            chk($sformatf("vec%0d_err", i), 32'(bus.rsp_err), 32'(vecs[i].err));
            chk($sformatf("vec%0d_tag", i), 32'(bus.rsp_tag), 32'(vecs[i].tag));
            finish_rsp($sformatf("vec%0d", i));
        end

        // Back-pressure: response must hold while a second request is offered.
        bus.rsp_ready = 1'b0;
        run_op(OP_ADD, 32'h00000010, 32'h00000020, 4'h3, cntl, lat);
        chk("stall_latency", 32'(lat), 32'(LAT));
        for (int k = 0; k < 5; k++) begin
            bus.req_valid = 1'b1;
            bus.req_op    = OP_OR;
            bus.req_a     = 32'hDEAD_BEEF;
            bus.req_b     = 32'h0BAD_F00D;
            bus.req_tag   = 4'hF;
            @(negedge clk);
            chk($sformatf("stall%0d_valid", k), 32'(bus.rsp_valid), 32'd1);
            chk($sformatf("stall%0d_req_ready", k), 32'(bus.req_ready), 32'd0);
            chk($sformatf("stall%0d_result", k), bus.rsp_result, 32'h00000030);
            chk($sformatf("stall%0d_tag", k), 32'(bus.rsp_tag), 32'h3);
        end
        bus.req_valid = 1'b0;
        finish_rsp("stall");
        chk("stall_alu_a_kept", bus.alu_a, 32'h00000010);
        chk("stall_cntl_kept", 32'(bus.alu_cntl), 32'(4'b1010));
        seen = 0;
        repeat (LAT + 2) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        chk("stall_second_not_taken", 32'(seen), 32'd0);

        // Reset while operands are being held on the ALU.
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op    = OP_SUB;
        bus.req_a     = 32'h0000_1234;
        bus.req_b     = 32'h0000_0034;
        bus.req_tag   = 4'h9;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("mid_drive_cntl", 32'(bus.alu_cntl), 32'(4'b1110));
        reset_n = 1'b0;
        #1;
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
        chk("abort_alu_cntl", 32'(bus.alu_cntl), 32'd0);
        chk("abort_alu_a", bus.alu_a, 32'd0);
        chk("abort_rsp_tag", 32'(bus.rsp_tag), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (LAT + 2) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        chk("abort_rsp_discarded", 32'(seen), 32'd0);
        prev_cntl = 4'b0000;

        // Randomized ops with random response stalls against the reference model.
        for (int n = 0; n < 120; n++) begin
            op_e         op;
            logic [31:0] a, b;
            logic [3:0]  tag;
            int          stall;
            op    = op_e'(4'($urandom_range(0, 15)));
            a     = pick_operand();
            b     = pick_operand();
            tag   = 4'($urandom);
            stall = $urandom_range(0, 2);
            bus.rsp_ready = (stall == 0);
            run_op(op, a, b, tag, cntl, lat);
            if (spec_legal(op)) prev_cntl = spec_cntl(op);
            check_rsp($sformatf("rnd%0d", n), op, a, b, tag, prev_cntl, cntl, lat);
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                chk($sformatf("rnd%0d_hold_valid", n), 32'(bus.rsp_valid), 32'd1);
                chk($sformatf("rnd%0d_hold_tag", n), 32'(bus.rsp_tag), 32'(tag));
            end
            finish_rsp($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
